// File: rtl/audio_pkg.sv
// Shared constants and assembler state encoding for the UART-to-codec audio sample path.
package audio_pkg;

    localparam int SAMPLE_W            = 16;
    localparam int DEPTH_DEFAULT       = 16;
    localparam int GAP_TIMEOUT_DEFAULT = 104000;

    typedef enum logic {
        LOW_WAIT  = 1'b0,
        HIGH_WAIT = 1'b1
    } asm_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO with extra-MSB pointers; a pop frees room for a same-cycle push when full.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/audio_sample_packer.sv
// Packs little-endian UART byte pairs into 16-bit samples and serves them to the codec on request.
// state     | meaning
// LOW_WAIT  | idle; next byte_valid is the low byte
// HIGH_WAIT | low byte held; gap timer running, next byte_valid completes the sample
module audio_sample_packer
    import audio_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEFAULT
) (
    input  logic                       CLK50MHz,
    input  logic                       RST,
    input  logic [7:0]                 byte_data,
    input  logic                       byte_valid,
    input  logic                       sample_req,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    output logic [$clog2(DEPTH):0]     level,
    input  logic                       clear_flags,
    output logic                       overflow,
    output logic                       underrun,
    output logic                       resync
);

    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

    asm_state_t          r_state;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [7:0]          r_low_byte;
    logic [SAMPLE_W-1:0] r_sample_out;
    logic                r_sample_valid;
    logic                r_overflow;
    logic                r_underrun;
    logic                r_resync;

    logic                w_push;
    logic                w_timeout;
    logic                w_full;
    logic                w_empty;
    logic [SAMPLE_W-1:0] w_rdata;
    logic                w_ovf_evt;
    logic                w_unr_evt;
    logic                w_rsy_evt;

    // The counter reaches GAP_TIMEOUT on this cycle's increment, i.e. the
    // GAP_TIMEOUT-th cycle spent in HIGH_WAIT is the last one a high byte may arrive.
    assign w_timeout = (r_state == HIGH_WAIT) && (r_gap_cnt == GAP_W'(GAP_TIMEOUT - 1));
    assign w_push    = (r_state == HIGH_WAIT) && byte_valid;
    assign w_ovf_evt = w_push && w_full && !sample_req;
    assign w_unr_evt = sample_req && w_empty;
    assign w_rsy_evt = w_timeout && !byte_valid;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .i_clk   (CLK50MHz),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_wdata ({byte_data, r_low_byte}),
        .i_pop   (sample_req),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    always_ff @(posedge CLK50MHz or posedge RST) begin
        if (RST) begin
            r_state        <= LOW_WAIT;
            r_gap_cnt      <= '0;
            r_low_byte     <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_overflow     <= 1'b0;
            r_underrun     <= 1'b0;
            r_resync       <= 1'b0;
        end else begin
            case (r_state)
                LOW_WAIT: begin
                    if (byte_valid) begin
                        r_low_byte <= byte_data;
                        r_gap_cnt  <= '0;
                        r_state    <= HIGH_WAIT;
                    end
                end
                HIGH_WAIT: begin
                    if (byte_valid) begin
                        r_state <= LOW_WAIT;
                    end else if (w_timeout) begin
                        r_low_byte <= '0;
                        r_state    <= LOW_WAIT;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: r_state <= LOW_WAIT;
            endcase

            r_sample_valid <= sample_req;
            if (sample_req) r_sample_out <= w_empty ? '0 : w_rdata;

            // A same-cycle setting event wins over clear_flags.
            r_overflow <= (r_overflow && !clear_flags) || w_ovf_evt;
            r_underrun <= (r_underrun && !clear_flags) || w_unr_evt;
            r_resync   <= (r_resync   && !clear_flags) || w_rsy_evt;
        end
    end

    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign overflow     = r_overflow;
    assign underrun     = r_underrun;
    assign resync       = r_resync;

endmodule

// File: tb/tb_audio_sample_packer.sv
// Randomised scoreboard bench for audio_sample_packer against a queue-based reference model.
module tb_audio_sample_packer;

    localparam int DEPTH = 8;
    localparam int GAP   = 20;

    logic        CLK50MHz;
    logic        RST;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        sample_req;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [$clog2(DEPTH):0] level;
    logic        clear_flags;
    logic        overflow;
    logic        underrun;
    logic        resync;

    audio_sample_packer #(
        .DEPTH       (DEPTH),
        .GAP_TIMEOUT (GAP)
    ) dut (
        .CLK50MHz     (CLK50MHz),
        .RST          (RST),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .sample_req   (sample_req),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .level        (level),
        .clear_flags  (clear_flags),
        .overflow     (overflow),
        .underrun     (underrun),
        .resync       (resync)
    );

    initial CLK50MHz = 1'b0;
    always #10 CLK50MHz = ~CLK50MHz;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb[$];
    logic [15:0] m_fifo[$];
    bit          m_have_low;
    logic [7:0]  m_low;
    int          m_low_cyc;
    int          cyc;
    bit          m_ovf, m_unr, m_rsy;
    logic [15:0] last_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: one clock cycle of the packer expressed as queue operations.
    task automatic model_cycle(input bit bv, input logic [7:0] bd, input bit req, input bit clr);
        bit push = 0;
        bit set_o = 0, set_u = 0, set_r = 0;
        logic [15:0] s = '0;
        if (m_have_low) begin
            if (bv) begin
                push = 1;
                s = {bd, m_low};
                m_have_low = 0;
            end else if (cyc - m_low_cyc == GAP) begin
                m_have_low = 0;
                set_r = 1;
            end
        end else if (bv) begin
            m_have_low = 1;
            m_low = bd;
            m_low_cyc = cyc;
        end
        if (req) begin
            if (m_fifo.size() > 0) sb.push_back(m_fifo.pop_front());
            else begin
                sb.push_back(16'h0000);
                set_u = 1;
            end
        end
        if (push) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(s);
            else set_o = 1;
        end
        m_ovf = (m_ovf && !clr) || set_o;
        m_unr = (m_unr && !clr) || set_u;
        m_rsy = (m_rsy && !clr) || set_r;
        cyc++;
    endtask

    task automatic check_state();
        check("level", 32'(level), 32'(m_fifo.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underrun", 32'(underrun), 32'(m_unr));
        check("resync", 32'(resync), 32'(m_rsy));
    endtask

    task automatic step(input bit bv, input logic [7:0] bd, input bit req, input bit clr);
        byte_valid  = bv;
        byte_data   = bd;
        sample_req  = req;
        clear_flags = clr;
        model_cycle(bv, bd, req, clr);
        @(posedge CLK50MHz);
        @(negedge CLK50MHz);
        byte_valid  = 1'b0;
        sample_req  = 1'b0;
        clear_flags = 1'b0;
        check_state();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic req();
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic clr();
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        #2;
        RST = 1'b1;
        byte_valid = 1'b0;
        sample_req = 1'b0;
        clear_flags = 1'b0;
        byte_data = 8'h00;
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_sample_out", 32'(sample_out), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_flags", {29'd0, overflow, underrun, resync}, 32'd0);
        m_fifo.delete();
        sb.delete();
        m_have_low = 0;
        m_ovf = 0;
        m_unr = 0;
        m_rsy = 0;
        last_out = '0;
        @(negedge CLK50MHz);
        RST = 1'b0;
    endtask

    always @(negedge CLK50MHz) begin
        if (!RST) begin
            if (sample_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got sample_out %0h with nothing expected", sample_out);
                end else begin
                    check("sample_out", 32'(sample_out), 32'(sb.pop_front()));
                end
                last_out = sample_out;
            end else begin
                check("sample_hold", 32'(sample_out), 32'(last_out));
            end
        end
    end

    initial begin
        RST = 1'b1;
        byte_valid = 1'b0;
        sample_req = 1'b0;
        clear_flags = 1'b0;
        byte_data = 8'h00;
        cyc = 0;
        m_low = '0;
        m_low_cyc = 0;
        @(negedge CLK50MHz);
        do_reset();

        // Basic little-endian assembly and one-cycle pop latency
        send(8'h34);
        send(8'h12);
        req();
        idle(2);

        // Gap longer than the timeout: 0xAA dropped, resync raised
        send(8'hAA);
        idle(GAP);
        send(8'h01);
        send(8'h80);
        req();
        idle(1);
        clr();

        // High byte landing exactly on the timeout cycle is still accepted
        send(8'h11);
        idle(GAP - 1);
        send(8'h22);
        req();
        idle(1);

        // Fill past capacity, then drain, then underrun
        for (int i = 0; i <= DEPTH; i++) begin
            send(8'(i * 3 + 1));
            send(8'(8'hC0 + i));
        end
        for (int i = 0; i < DEPTH; i++) req();
        req();
        idle(1);
        clr();

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) begin
            send(8'(8'h50 + i));
            send(8'(8'h70 + i));
        end
        send(8'h9A);
        step(1'b1, 8'hBC, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) req();
        idle(1);

        // Reset between low and high byte
        send(8'hEE);
        do_reset();
        send(8'h78);
        send(8'h56);
        req();
        idle(1);

        // Randomised phases with varying byte/request densities
        for (int ph = 0; ph < 4; ph++) begin
            int pbv;
            int prq;
            case (ph)
                0: begin pbv = 40; prq = 30; end
                1: begin pbv = 3;  prq = 10; end
                2: begin pbv = 60; prq = 5;  end
                default: begin pbv = 20; prq = 40; end
            endcase
            for (int i = 0; i < 800; i++) begin
                step(($urandom_range(0, 99) < pbv) ? 1'b1 : 1'b0,
                     8'($urandom_range(0, 255)),
                     ($urandom_range(0, 99) < prq) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
            end
        end
        idle(3);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
